aud_play_sched: RTL

- Playback scheduler that drives the I2S DAC serializer (AudPlayer) from sample memory.
- Fetches interleaved stereo words (L at even address, R at odd address) from SRAM and prefetches one frame ahead.
- Hands each frame to the serializer at every left-channel frame boundary of DACLRCK.
- Supports play, pause, stop, fast-forward (sample skip) and slow-motion (sample repeat); sits between the top-level control FSM and AudPlayer.

---
 rtl/aud_pkg.sv | 54 +++++
 rtl/aud_play_sched_if.sv | 29 ++
 rtl/lrck_edge_det.sv | 22 ++
 rtl/aud_play_sched.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aud_pkg
// Description : Shared types, widths and pointer-advance helper for the
//               audio playback scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package aud_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int SPD_W  = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_L = 3'd1,
    WAIT_L  = 3'd2,
    FETCH_R = 3'd3,
    WAIT_R  = 3'd4,
    READY   = 3'd5,
    PAUSE   = 3'd6,
    DONE    = 3'd7
  } play_state_e;

  typedef struct packed {
    logic [ADDR_W:0]  ptr;
    logic [SPD_W-1:0] rep_cnt;
  } next_ptr_t;

  // One extra pointer bit so the end-of-data compare can never wrap.
  function automatic next_ptr_t next_ptr(
    input logic [ADDR_W-1:0] ptr,
    input logic              fast,
    input logic              slow,
    input logic [SPD_W-1:0]  speed,
    input logic [SPD_W-1:0]  rep_cnt
  );
    next_ptr_t       r;
    logic [ADDR_W:0] base;
    base      = {1'b0, ptr};
    r.rep_cnt = '0;
    if (fast) begin
      r.ptr = base + {{(ADDR_W-SPD_W){1'b0}}, speed, 1'b0} + (ADDR_W+1)'(2);
    end else if (slow && (rep_cnt != speed)) begin
      r.ptr     = base;
      r.rep_cnt = rep_cnt + SPD_W'(1);
    end else begin
      r.ptr = base + (ADDR_W+1)'(2);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aud_play_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : aud_play_sched_if
// Description : SRAM read port and AudPlayer/DAC-side signals of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface aud_play_sched_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] o_sram_addr;
  logic              o_sram_rd;
  logic [DATA_W-1:0] i_sram_rdata;
  logic              i_daclrck;
  logic [DATA_W-1:0] o_dac_l;
  logic [DATA_W-1:0] o_dac_r;
  logic              o_player_en;

  modport master (
    output o_sram_addr, o_sram_rd, o_dac_l, o_dac_r, o_player_en,
    input  i_sram_rdata, i_daclrck
  );

  modport slave (
    input  o_sram_addr, o_sram_rd, o_dac_l, o_dac_r, o_player_en,
    output i_sram_rdata, i_daclrck
  );
endinterface
`default_nettype wire

// File: rtl/lrck_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : lrck_edge_det
// Description : Flags the start of a left half-frame (DACLRCK falling edge).
// Revision    : 1.0 - initial release
// ============================================================================
module lrck_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_daclrck,
  output logic o_fb
);
  logic r_lrck_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_lrck_d <= 1'b1;
    else       r_lrck_d <= i_daclrck;
  end

  assign o_fb = r_lrck_d & ~i_daclrck;
endmodule
`default_nettype wire

// File: rtl/aud_play_sched.sv
`default_nettype none
// ============================================================================
// Module      : aud_play_sched
// Description : Prefetches stereo frames from SRAM and hands them to the I2S
//               serializer at each left-channel frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module aud_play_sched #(
  parameter int ADDR_W = aud_pkg::ADDR_W,
  parameter int DATA_W = aud_pkg::DATA_W,
  parameter int SPD_W  = aud_pkg::SPD_W,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic              i_slow,
  input  logic [SPD_W-1:0]  i_speed,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  aud_play_sched_if.master  bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_underrun,
  output logic [ADDR_W-1:0] o_cur_addr
);
  import aud_pkg::*;

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  play_state_e       r_state;
  logic [ADDR_W-1:0] r_ptr, r_sram_addr, r_cur_addr;
  logic [SPD_W-1:0]  r_rep;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [DATA_W-1:0] r_pre_l, r_pre_r, r_dac_l, r_dac_r;
  logic              r_sram_rd, r_player_en, r_busy, r_done, r_underrun;
  logic              w_fb, w_past_end, w_lat_hit;
  next_ptr_t         w_next;

  lrck_edge_det u_edge (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_daclrck (bus.i_daclrck),
    .o_fb      (w_fb)
  );

  assign w_next     = next_ptr(r_ptr, i_fast, i_slow, i_speed, r_rep);
  assign w_past_end = (w_next.ptr + (ADDR_W+1)'(1)) > {1'b0, i_end_addr};
  assign w_lat_hit  = (r_lat_cnt == LAT_W'(RD_LAT-1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_rep       <= '0;
      r_lat_cnt   <= '0;
      r_pre_l     <= '0;
      r_pre_r     <= '0;
      r_dac_l     <= '0;
      r_dac_r     <= '0;
      r_sram_addr <= '0;
      r_sram_rd   <= 1'b0;
      r_cur_addr  <= '0;
      r_player_en <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
    end else if (i_stop) begin
      r_state     <= IDLE;
      r_dac_l     <= '0;
      r_dac_r     <= '0;
      r_sram_addr <= '0;
      r_sram_rd   <= 1'b0;
      r_cur_addr  <= '0;
      r_player_en <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_sram_rd  <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_dac_l     <= '0;
          r_dac_r     <= '0;
          r_player_en <= 1'b0;
          if (i_start) begin
            r_ptr       <= i_start_addr;
            r_rep       <= '0;
            r_sram_rd   <= 1'b1;
            r_sram_addr <= i_start_addr;
            r_busy      <= 1'b1;
            r_state     <= FETCH_L;
          end
        end
        FETCH_L, FETCH_R: begin
          r_underrun <= w_fb;
          r_lat_cnt  <= '0;
          r_state    <= (r_state == FETCH_L) ? WAIT_L : WAIT_R;
        end
        WAIT_L: begin
          r_underrun <= w_fb;
          if (w_lat_hit) begin
            r_pre_l     <= bus.i_sram_rdata;
            r_sram_rd   <= 1'b1;
            r_sram_addr <= r_ptr + ADDR_W'(1);
            r_state     <= FETCH_R;
          end else begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          end
        end
        WAIT_R: begin
          r_underrun <= w_fb;
          if (w_lat_hit) begin
            r_pre_r <= bus.i_sram_rdata;
            r_state <= i_pause ? PAUSE : READY;
          end else begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          end
        end
        READY: begin
          // Pause takes precedence over a coincident boundary: the frame is held.
          if (i_pause) begin
            r_state <= PAUSE;
          end else if (w_fb) begin
            r_dac_l     <= r_pre_l;
            r_dac_r     <= r_pre_r;
            r_cur_addr  <= r_ptr;
            r_player_en <= 1'b1;
            r_rep       <= w_next.rep_cnt;
            if (w_past_end) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= DONE;
            end else begin
              r_ptr       <= w_next.ptr[ADDR_W-1:0];
              r_sram_rd   <= 1'b1;
              r_sram_addr <= w_next.ptr[ADDR_W-1:0];
              r_state     <= FETCH_L;
            end
          end
        end
        PAUSE: begin
          if (!i_pause) r_state <= READY;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_sram_addr = r_sram_addr;
  assign bus.o_sram_rd   = r_sram_rd;
  assign bus.o_dac_l     = r_dac_l;
  assign bus.o_dac_r     = r_dac_r;
  assign bus.o_player_en = r_player_en;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_underrun      = r_underrun;
  assign o_cur_addr      = r_cur_addr;
endmodule
`default_nettype wire
